// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - core-local interruptor: mtime, mtimecmp, msip, timer/software IRQs (option macro: CLINT_RTC_EN)
module clint_timer #(
  parameter int unsigned clk_divider_rtc = 380
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic [15:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        tick;
  logic        msip;
  logic        mtip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] rdata_q;
  logic [31:0] read_mux;
  logic [15:0] word_addr;
  logic        accept;
  logic        wr;
  logic        wr_msip;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_mt_lo;
  logic        wr_mt_hi;
  logic        unused_addr;

  // Byte-lane merge of write data into an existing 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

`ifdef CLINT_RTC_EN
  logic [31:0] pre;
  logic        rtc;

  // Prescaler: pre counts 0..clk_divider_rtc, wrapping and toggling rtc at terminal count.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= 32'd0;
      rtc <= 1'b0;
    end else if (pre == clk_divider_rtc) begin
      pre <= 32'd0;
      rtc <= ~rtc;
    end else begin
      pre <= pre + 32'd1;
    end
  end

  // One tick per full rtc period, so the first tick lands 2*(div+1) clocks after reset.
  assign tick = (pre == clk_divider_rtc) && rtc;
`else
  logic unused_div;
  assign unused_div = ^clk_divider_rtc;
  assign tick       = 1'b1;
`endif

  assign unused_addr = ^clint_addr[1:0];
  assign word_addr   = {clint_addr[15:2], 2'b00};
  assign accept      = (state == S_IDLE) && clint_valid;
  assign wr          = accept && (clint_wstrb != 4'b0000);
  assign wr_msip     = wr && (word_addr == 16'h0000);
  assign wr_cmp_lo   = wr && (word_addr == 16'h4000);
  assign wr_cmp_hi   = wr && (word_addr == 16'h4004);
  assign wr_mt_lo    = wr && (word_addr == 16'hBFF8);
  assign wr_mt_hi    = wr && (word_addr == 16'hBFFC);

  // Read decode of the register map; unmapped offsets read as zero.
  always_comb begin
    read_mux = 32'd0;
    case (word_addr)
      16'h0000: read_mux = {31'd0, msip};
      16'h4000: read_mux = mtimecmp[31:0];
      16'h4004: read_mux = mtimecmp[63:32];
      16'hBFF8: read_mux = mtime[31:0];
      16'hBFFC: read_mux = mtime[63:32];
      default:  read_mux = 32'd0;
    endcase
  end

  // Register file: a bus write to an mtime half wins over the tick and suppresses the whole increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      msip     <= 1'b0;
      mtip     <= 1'b0;
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      rdata_q  <= 32'd0;
    end else begin
      if (wr_msip && clint_wstrb[0]) msip <= clint_wdata[0];
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0],  clint_wdata, clint_wstrb);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], clint_wdata, clint_wstrb);
      if (wr_mt_lo) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], clint_wdata, clint_wstrb);
      end else if (wr_mt_hi) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], clint_wdata, clint_wstrb);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      mtip <= (mtime >= mtimecmp);
      if (accept) rdata_q <= read_mux;
    end
  end

  // Bus FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Bus FSM next state and response outputs; reset suppresses an in-flight response.
  always_comb begin
    state_next  = state;
    clint_ready = 1'b0;
    clint_rdata = 32'd0;
    case (state)
      S_IDLE: if (clint_valid) state_next = S_RESP;
      S_RESP: begin
        state_next  = S_IDLE;
        clint_ready = !reset;
        clint_rdata = reset ? 32'd0 : rdata_q;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign clint_msip  = msip;
  assign clint_mtip  = mtip;
  assign clint_mtime = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - randomized self-checking bench for clint_timer against a behavioural model
module tb_clint_timer;

  localparam int DIV = 3;
`ifdef CLINT_RTC_EN
  localparam int P = 2 * (DIV + 1);
`else
  localparam int P = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clint_valid = 1'b0;
  logic [15:0] clint_addr = 16'd0;
  logic [31:0] clint_wdata = 32'd0;
  logic [3:0]  clint_wstrb = 4'd0;
  logic [31:0] clint_rdata;
  logic        clint_ready;
  logic        clint_msip;
  logic        clint_mtip;
  logic [63:0] clint_mtime;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [63:0] m_mt;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_mtip;
  logic        m_resp;
  logic [31:0] m_rdata;
  int          ecnt;

  clint_timer #(.clk_divider_rtc(DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .clint_valid (clint_valid),
    .clint_addr  (clint_addr),
    .clint_wdata (clint_wdata),
    .clint_wstrb (clint_wstrb),
    .clint_rdata (clint_rdata),
    .clint_ready (clint_ready),
    .clint_msip  (clint_msip),
    .clint_mtip  (clint_mtip),
    .clint_mtime (clint_mtime)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [15:0] w;
    w = {a[15:2], 2'b00};
    case (w)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mt[31:0];
      16'hBFFC: return m_mt[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge, then compare.
  task automatic step();
    logic        tick;
    logic        wrote_mt;
    logic        nmtip;
    logic [15:0] w;
    @(posedge clock);
    if (reset) begin
      m_mt = 64'd0; m_cmp = '1; m_msip = 1'b0; m_mtip = 1'b0;
      m_resp = 1'b0; m_rdata = 32'd0; ecnt = 0;
    end else begin
      ecnt++;
      tick     = (ecnt % P) == 0;
      nmtip    = (m_mt >= m_cmp);
      wrote_mt = 1'b0;
      w        = {clint_addr[15:2], 2'b00};
      if (m_resp) begin
        m_resp = 1'b0;
        m_rdata = 32'd0;
      end else if (clint_valid) begin
        m_resp  = 1'b1;
        m_rdata = m_read(clint_addr);
        if (clint_wstrb != 4'd0) begin
          case (w)
            16'h0000: if (clint_wstrb[0]) m_msip = clint_wdata[0];
            16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0],  clint_wdata, clint_wstrb);
            16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], clint_wdata, clint_wstrb);
            16'hBFF8: begin m_mt[31:0]  = merge(m_mt[31:0],  clint_wdata, clint_wstrb); wrote_mt = 1'b1; end
            16'hBFFC: begin m_mt[63:32] = merge(m_mt[63:32], clint_wdata, clint_wstrb); wrote_mt = 1'b1; end
            default: ;
          endcase
        end
      end
      if (!wrote_mt && tick) m_mt = m_mt + 64'd1;
      m_mtip = nmtip;
    end
    #1;
    chk("mtime", clint_mtime, m_mt);
    chk("mtip",  {63'd0, clint_mtip}, {63'd0, m_mtip});
    chk("msip",  {63'd0, clint_msip}, {63'd0, m_msip});
    chk("ready", {63'd0, clint_ready}, {63'd0, m_resp});
    chk("rdata", {32'd0, clint_rdata}, {32'd0, (m_resp ? m_rdata : 32'd0)});
  endtask

  task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    clint_valid = 1'b1;
    clint_addr  = a;
    clint_wdata = d;
    clint_wstrb = s;
    step();
    clint_valid = 1'b0;
    clint_wstrb = 4'd0;
    step();
  endtask

  logic [15:0] addrs [0:6];
  logic        seen;

  initial begin
    addrs[0] = 16'h0000; addrs[1] = 16'h4000; addrs[2] = 16'h4004;
    addrs[3] = 16'hBFF8; addrs[4] = 16'hBFFC; addrs[5] = 16'h1234; addrs[6] = 16'h4003;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Free-running count from reset release (mtime=1 at clock 2*(DIV+1) in RTC mode)
    repeat (2 * P + 4) step();

    // msip: set, clear, then a non-lane-0 write leaves it alone
    bus(16'h0000, 32'h1, 4'h1);
    chk("msip_set", {63'd0, clint_msip}, 64'd1);
    bus(16'h0000, 32'h0, 4'h1);
    bus(16'h0001, 32'hFFFF_FFFF, 4'h1);
    bus(16'h0000, 32'h0000_0001, 4'h2);
    chk("msip_wstrb2", {63'd0, clint_msip}, 64'd1);

    // mtimecmp a few ticks ahead; mtip must rise, then drop after raising the hi word
    bus(16'h4004, m_mt[63:32], 4'hF);
    bus(16'h4000, m_mt[31:0] + 32'd3, 4'hF);
    seen = 1'b0;
    repeat (4 * P + 6) begin
      step();
      if (clint_mtip) seen = 1'b1;
    end
    chk("mtip_rise", {63'd0, seen}, 64'd1);
    bus(16'h4004, m_cmp[63:32] + 32'd1, 4'hF);
    step();
    chk("mtip_drop", {63'd0, clint_mtip}, 64'd0);

    // mtime wrap: load all ones, wait for a tick
    bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    repeat (P + 1) step();
    bus(16'hBFFC, 32'd0, 4'h0);

    // Write lo on the same edge as a tick: increment dropped
    while (((ecnt + 1) % P) != 0) step();
    clint_valid = 1'b1; clint_addr = 16'hBFF8; clint_wdata = 32'h10; clint_wstrb = 4'hF;
    step();
    chk("same_cycle_lo", {32'd0, clint_mtime[31:0]}, 64'h10);
    clint_valid = 1'b0; clint_wstrb = 4'd0;
    repeat (P + 1) step();

    // Unmapped read and register readback
    bus(16'h1234, 32'd0, 4'h0);
    for (int i = 0; i < 5; i++) bus(addrs[i], 32'd0, 4'h0);

    // Randomized transactions, including held valid and idle gaps
    for (int i = 0; i < 150; i++) begin
      clint_valid = 1'b1;
      clint_addr  = addrs[$urandom_range(0, 6)] | 16'($urandom_range(0, 3));
      clint_wdata = $urandom;
      clint_wstrb = 4'($urandom_range(0, 15));
      step();
      if ($urandom_range(0, 3) != 0) begin
        clint_valid = 1'b0;
        clint_wstrb = 4'd0;
      end
      step();
      repeat ($urandom_range(0, 2)) begin
        clint_valid = 1'b0;
        step();
      end
    end
    clint_valid = 1'b0;
    clint_wstrb = 4'd0;
    step();

    // Reset in the cycle after the request: no ready pulse, everything back to reset values
    clint_valid = 1'b1; clint_addr = 16'h0000; clint_wdata = 32'h1; clint_wstrb = 4'h1;
    @(posedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ready", {63'd0, clint_ready}, 64'd0);
    chk("abort_rdata", {32'd0, clint_rdata}, 64'd0);
    clint_valid = 1'b0; clint_wstrb = 4'd0;
    step();
    chk("abort_mtime", clint_mtime, 64'd0);
    reset = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
